// File: rtl/sig_mult_iter_if.sv
// rtl/sig_mult_iter_if.sv - operand/result handshake bundle for the iterative significand multiplier
interface sig_mult_iter_if #(
   parameter int WSIG    = 23,
   parameter int WEXPSUM = 10
);
   logic                  in_valid;
   logic                  in_ready;
   logic [WSIG:0]         norma;
   logic [WSIG:0]         normb;
   logic [WEXPSUM-1:0]    modexpa;
   logic [WEXPSUM-1:0]    modexpb;
   logic                  signa;
   logic                  signb;
   logic                  out_valid;
   logic                  out_ready;
   logic [2*WSIG+1:0]     product;
   logic [WEXPSUM-1:0]    expsum;
   logic                  sign_out;

   modport master (
      output in_valid, norma, normb, modexpa, modexpb, signa, signb, out_ready,
      input  in_ready, out_valid, product, expsum, sign_out
   );

   modport slave (
      input  in_valid, norma, normb, modexpa, modexpb, signa, signb, out_ready,
      output in_ready, out_valid, product, expsum, sign_out
   );
endinterface

// File: rtl/sig_mult_iter.sv
// rtl/sig_mult_iter.sv - radix-2 shift-add significand multiplier with exponent add and sign XOR
// Optional zero-operand short cut enabled by defining SIG_MULT_ZERO_BYPASS_EN.
module sig_mult_iter #(
   parameter int WSIG    = 23,
   parameter int WEXPSUM = 10,
   parameter int BIAS    = 127
) (
   input logic             clk,
   input logic             reset_n,
   sig_mult_iter_if.slave  bus
);
   localparam int WPROD = 2*WSIG + 2;
   localparam int WCNT  = $clog2(WSIG + 1);
   localparam logic [WEXPSUM-1:0] BIAS_W = WEXPSUM'(BIAS);
   localparam logic [WCNT-1:0]    LAST_IT = WCNT'(WSIG);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t              state;
   logic [WPROD-1:0]    mcand;
   logic [WSIG:0]       mplier;
   logic [WPROD-1:0]    acc;
   logic [WCNT-1:0]     cnt;
   logic [WEXPSUM-1:0]  expsum_q;
   logic                sign_q;
   logic                in_ready_q;
   logic                out_valid_q;

`ifdef SIG_MULT_ZERO_BYPASS_EN
   logic zero_op;
   assign zero_op = (bus.norma == '0) || (bus.normb == '0);
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         mcand       <= '0;
         mplier      <= '0;
         acc         <= '0;
         cnt         <= '0;
         expsum_q    <= '0;
         sign_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  mcand      <= WPROD'(bus.norma);
                  mplier     <= bus.normb;
                  acc        <= '0;
                  cnt        <= '0;
                  // Wraps modulo 2^WEXPSUM; range checks happen in post-normalization.
                  expsum_q   <= bus.modexpa + bus.modexpb - BIAS_W;
                  sign_q     <= bus.signa ^ bus.signb;
                  in_ready_q <= 1'b0;
`ifdef SIG_MULT_ZERO_BYPASS_EN
                  if (zero_op) begin
                     state       <= DONE;
                     out_valid_q <= 1'b1;
                  end else begin
                     state <= BUSY;
                  end
`else
                  state <= BUSY;
`endif
               end
            end
            BUSY: begin
               // Multiplicand is pre-shifted one place per iteration, equivalent to << cnt.
               if (mplier[0]) acc <= acc + mcand;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + WCNT'(1);
               if (cnt == LAST_IT) begin
                  state       <= DONE;
                  out_valid_q <= 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state       <= IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state       <= IDLE;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.product   = acc;
   assign bus.expsum    = expsum_q;
   assign bus.sign_out  = sign_q;

endmodule
